// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// i2c_target: I2C target (slave) register-port responder.
// Decodes START/STOP, device address, register pointer and data bytes from an
// oversampled SCL/SDA pair; issues register write strobes and serves reads.
// Optional build macro: I2C_TARGET_AUTOINC_EN -- pointer auto-increments after
// each written byte and each ACKed read byte; otherwise only a REG byte moves it.
// Ports:
//   CLK, RST_N      system clock (>= 16x SCL), async active-low reset
//   SCL_IN, SDA_IN  asynchronous bus inputs
//   SDA_OE          1 = pull SDA low
//   wr_en/addr/data one-cycle register write strobe with address and data
//   rd_addr/rd_data register pointer out, register contents in (1 CLK latency)
//   busy            addressed transaction in progress (matched START to STOP)
module i2c_target #(
  parameter logic [6:0]  DEV_ADDR    = 7'h39,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, IGNORE, ADDR_ACK, REG, REG_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]             byte_in;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] shift;
  logic [7:0] ptr;
  logic       rw;
  logic       ack_phase;

  // Synchronizers plus one history flop; reset to the idle-bus level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL_IN};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA_IN};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  // SCL must be high on both sides of the SDA edge to qualify as START/STOP.
  assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;
  assign byte_in   = {shift[6:0], sda_s};
  assign rd_addr   = ptr;

  // Protocol FSM with registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      shift     <= 8'd0;
      ptr       <= 8'd0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      SDA_OE    <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 8'd0;
      busy      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (start_det) begin
        // SDA cannot fall while we hold it, so OE is already 0 here.
        state     <= ADDR;
        cnt       <= 4'd0;
        ack_phase <= 1'b0;
        SDA_OE    <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        ack_phase <= 1'b0;
        SDA_OE    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE, IGNORE: ;
          ADDR: if (scl_rise) begin
            shift <= byte_in;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt <= 4'd0;
              rw  <= sda_s;
              if (byte_in[7:1] == DEV_ADDR) begin
                state <= ADDR_ACK;
                busy  <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          REG: if (scl_rise) begin
            shift <= byte_in;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt   <= 4'd0;
              ptr   <= byte_in;
              state <= REG_ACK;
            end
          end
          WDATA: if (scl_rise) begin
            shift <= byte_in;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt     <= 4'd0;
              wr_en   <= 1'b1;
              wr_addr <= ptr;
              wr_data <= byte_in;
`ifdef I2C_TARGET_AUTOINC_EN
              ptr     <= ptr + 8'd1;
`endif
              state   <= WDATA_ACK;
            end
          end
          // First fall drives the ACK, second fall releases it and moves on.
          ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              SDA_OE    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              cnt       <= 4'd0;
              if (state == ADDR_ACK && rw) begin
                shift  <= {rd_data[6:0], 1'b0};
                SDA_OE <= ~rd_data[7];
                state  <= RDATA;
              end else begin
                SDA_OE <= 1'b0;
                state  <= (state == ADDR_ACK) ? REG : WDATA;
              end
            end
          end
          // cnt counts bits already clocked out; shift[7] is the next bit.
          RDATA: if (scl_rise) begin
            cnt <= cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              cnt    <= 4'd0;
              SDA_OE <= 1'b0;
              state  <= RDATA_ACK;
            end else begin
              SDA_OE <= ~shift[7];
              shift  <= {shift[6:0], 1'b0};
            end
          end
          // ack_phase marks an ACK seen; the reload waits for the next fall.
          RDATA_ACK: if (scl_rise) begin
            if (sda_s) begin
              state <= IGNORE;
            end else begin
              ack_phase <= 1'b1;
`ifdef I2C_TARGET_AUTOINC_EN
              ptr       <= ptr + 8'd1;
`endif
            end
          end else if (scl_fall && ack_phase) begin
            ack_phase <= 1'b0;
            cnt       <= 4'd0;
            shift     <= {rd_data[6:0], 1'b0};
            SDA_OE    <= ~rd_data[7];
            state     <= RDATA;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
// tb_i2c_target: randomized bus-level bench for i2c_target with a register-file
// reference model (pointer + memory) kept at transaction level.
module tb_i2c_target;
`ifdef I2C_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int Q = 8; // CLK cycles per quarter SCL period

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_bus;
  logic       SDA_OE, wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [7:0] rd_data = 8'd0;

  logic [7:0]  env_mem [256];
  logic [7:0]  model_mem [256];
  logic [7:0]  model_ptr;
  logic [15:0] wr_log [$];
  int          oe_cycles = 0;
  int          checks = 0;
  int          failures = 0;

  assign sda_bus = sda_drv & ~SDA_OE;
  always #5 CLK = ~CLK;

  i2c_target #(.DEV_ADDR(7'h39), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .SCL_IN(scl), .SDA_IN(sda_bus), .SDA_OE(SDA_OE),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy)
  );

  // External register file behind the read/write port.
  always @(posedge CLK) begin
    rd_data <= env_mem[rd_addr];
    if (wr_en) env_mem[wr_addr] = wr_data;
  end

  always @(posedge CLK) begin
    if (wr_en) wr_log.push_back({wr_addr, wr_data});
    if (SDA_OE) oe_cycles <= oe_cycles + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; scl = 1'b1; tick(Q);
    sda_drv = 1'b0; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic bus_rstart();
    sda_drv = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    sda_drv = 1'b0; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    sda_drv = 1'b1; tick(2*Q);
  endtask

  task automatic wbyte(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = b[i]; tick(Q);
      scl = 1'b1; tick(2*Q);
      scl = 1'b0; tick(Q);
    end
    sda_drv = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    ack = sda_bus; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic rbyte(input bit nack, output logic [7:0] b);
    sda_drv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(Q);
      scl = 1'b1; tick(Q);
      b[i] = sda_bus; tick(Q);
      scl = 1'b0; tick(Q);
    end
    sda_drv = nack; tick(Q);
    scl = 1'b1; tick(2*Q);
    scl = 1'b0; tick(Q);
    sda_drv = 1'b1;
  endtask

  task automatic test_reset();
    #2 RST_N = 1'b0;
    tick(3);
    checks++; if (SDA_OE !== 1'b0) begin failures++; $display("FAIL rst_oe got=%b exp=0", SDA_OE); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
    checks++; if (wr_addr !== 8'h00) begin failures++; $display("FAIL rst_wr_addr got=%h exp=00", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin failures++; $display("FAIL rst_wr_data got=%h exp=00", wr_data); end
    checks++; if (rd_addr !== 8'h00) begin failures++; $display("FAIL rst_rd_addr got=%h exp=00", rd_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    RST_N = 1'b1;
    tick(6);
    model_ptr = 8'h00;
    checks++; if ({busy, SDA_OE} !== 2'b00) begin failures++; $display("FAIL post_rst_idle got=%b exp=00", {busy, SDA_OE}); end
  endtask

  task automatic test_single_write();
    for (int n = 0; n < 4; n++) begin
      logic [7:0] ra, d;
      bit a0, a1, a2;
      int base;
      ra = (n == 0) ? 8'h41 : 8'($urandom);
      d  = (n == 0) ? 8'h10 : 8'($urandom);
      base = wr_log.size();
      bus_start(); wbyte(8'h72, a0); wbyte(ra, a1); wbyte(d, a2);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sw_busy_hi got=%b exp=1", busy); end
      bus_stop();
      model_mem[ra] = d;
      model_ptr = AUTOINC ? 8'(ra + 8'd1) : ra;
      checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL sw_acks got=%b exp=000", {a0, a1, a2}); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sw_busy_lo got=%b exp=0", busy); end
      checks++; if (wr_log.size() !== base + 1) begin failures++; $display("FAIL sw_count got=%0d exp=%0d", wr_log.size() - base, 1); end
      else begin
        checks++; if (wr_log[base] !== {ra, d}) begin failures++; $display("FAIL sw_entry got=%h exp=%h", wr_log[base], {ra, d}); end
      end
      checks++; if (rd_addr !== model_ptr) begin failures++; $display("FAIL sw_ptr got=%h exp=%h", rd_addr, model_ptr); end
    end
  endtask

  task automatic test_wrong_addr();
    for (int n = 0; n < 4; n++) begin
      logic [7:0] ad;
      bit a0, a1, a2;
      int base, oe0;
      ad = (n == 0) ? 8'h74 : 8'($urandom);
      if (ad[7:1] == 7'h39) ad = 8'(ad ^ 8'h80);
      base = wr_log.size();
      oe0 = oe_cycles;
      bus_start(); wbyte(ad, a0); wbyte(8'h41, a1); wbyte(8'h10, a2);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wa_busy got=%b exp=0", busy); end
      bus_stop();
      checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL wa_acks got=%b exp=111", {a0, a1, a2}); end
      checks++; if (oe_cycles !== oe0) begin failures++; $display("FAIL wa_oe got=%0d exp=%0d", oe_cycles, oe0); end
      checks++; if (wr_log.size() !== base) begin failures++; $display("FAIL wa_wr got=%0d exp=%0d", wr_log.size(), base); end
    end
  endtask

  // Write pointer, repeated START, read nbytes (ACK all but last).
  task automatic read_burst(input logic [7:0] ra, input int nbytes, input string tag);
    bit a0, a1, a2;
    logic [7:0] got, exp;
    bus_start(); wbyte(8'h72, a0); wbyte(ra, a1);
    bus_rstart(); wbyte(8'h73, a2);
    model_ptr = ra;
    checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL %s_acks got=%b exp=000", tag, {a0, a1, a2}); end
    for (int k = 0; k < nbytes; k++) begin
      exp = model_mem[model_ptr];
      rbyte(k == nbytes - 1, got);
      if (k != nbytes - 1 && AUTOINC) model_ptr = 8'(model_ptr + 8'd1);
      checks++; if (got !== exp) begin failures++; $display("FAIL %s_data%0d got=%h exp=%h", tag, k, got, exp); end
      checks++; if (rd_addr !== model_ptr) begin failures++; $display("FAIL %s_ptr%0d got=%h exp=%h", tag, k, rd_addr, model_ptr); end
    end
    bus_stop();
    checks++; if ({busy, SDA_OE} !== 2'b00) begin failures++; $display("FAIL %s_end got=%b exp=00", tag, {busy, SDA_OE}); end
  endtask

  task automatic test_read();
    env_mem[8'h42] = 8'h60;
    model_mem[8'h42] = 8'h60;
    read_burst(8'h42, 1, "rd42");
    checks++; if (rd_addr !== 8'h42) begin failures++; $display("FAIL rd42_keep got=%h exp=42", rd_addr); end
    for (int n = 0; n < 2; n++) read_burst(8'($urandom), 3, "rdrand");
  endtask

  task automatic test_burst_write();
    for (int n = 0; n < 2; n++) begin
      logic [7:0] ra, d, ea;
      logic [7:0] dq [$];
      bit a, acks;
      int base, len;
      ra = (n == 0) ? 8'h98 : 8'($urandom);
      len = (n == 0) ? 2 : 4;
      dq = {};
      for (int k = 0; k < len; k++) begin
        d = (n == 0) ? ((k == 0) ? 8'h03 : 8'hE0) : 8'($urandom);
        dq.push_back(d);
      end
      base = wr_log.size();
      acks = 1'b0;
      bus_start(); wbyte(8'h72, a); acks |= a; wbyte(ra, a); acks |= a;
      for (int k = 0; k < len; k++) begin wbyte(dq[k], a); acks |= a; end
      bus_stop();
      checks++; if (acks !== 1'b0) begin failures++; $display("FAIL bw_acks got=%b exp=0", acks); end
      checks++; if (wr_log.size() !== base + len) begin failures++; $display("FAIL bw_count got=%0d exp=%0d", wr_log.size() - base, len); end
      else begin
        for (int k = 0; k < len; k++) begin
          ea = AUTOINC ? 8'(ra + 8'(k)) : ra;
          model_mem[ea] = dq[k];
          checks++; if (wr_log[base + k] !== {ea, dq[k]}) begin failures++; $display("FAIL bw_entry%0d got=%h exp=%h", k, wr_log[base + k], {ea, dq[k]}); end
        end
      end
      model_ptr = AUTOINC ? 8'(ra + 8'(len)) : ra;
      checks++; if (rd_addr !== model_ptr) begin failures++; $display("FAIL bw_ptr got=%h exp=%h", rd_addr, model_ptr); end
    end
  endtask

  task automatic test_wrap_read();
    read_burst(8'hFF, 2, "wrap");
  endtask

  task automatic test_reset_mid();
    logic [7:0] r, d;
    bit a0, a1, a2;
    int base, oe0, waited;
    r = 8'($urandom);
    d = 8'($urandom) & 8'h7F;
    env_mem[r] = d;
    model_mem[r] = d;
    bus_start(); wbyte(8'h72, a0); wbyte(r, a1); bus_rstart(); wbyte(8'h73, a2);
    checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL rm_acks got=%b exp=000", {a0, a1, a2}); end
    waited = 0;
    while (SDA_OE !== 1'b1 && waited < 40) begin tick(1); waited++; end
    checks++; if (SDA_OE !== 1'b1) begin failures++; $display("FAIL rm_drive got=%b exp=1", SDA_OE); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if (SDA_OE !== 1'b0) begin failures++; $display("FAIL rm_async_oe got=%b exp=0", SDA_OE); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_async_busy got=%b exp=0", busy); end
    tick(4);
    RST_N = 1'b1;
    model_ptr = 8'h00;
    tick(4);
    checks++; if (rd_addr !== 8'h00) begin failures++; $display("FAIL rm_ptr got=%h exp=00", rd_addr); end
    base = wr_log.size();
    oe0 = oe_cycles;
    wbyte(8'h72, a0); wbyte(8'h41, a1); wbyte(8'h10, a2);
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL rm_ignore_acks got=%b exp=111", {a0, a1, a2}); end
    checks++; if (oe_cycles !== oe0 || wr_log.size() !== base || busy !== 1'b0) begin
      failures++; $display("FAIL rm_ignore got=oe%0d/wr%0d/busy%b exp=oe%0d/wr%0d/busy0", oe_cycles, wr_log.size(), busy, oe0, base);
    end
    bus_stop();
    r = 8'($urandom); d = 8'($urandom);
    bus_start(); wbyte(8'h72, a0); wbyte(r, a1); wbyte(d, a2); bus_stop();
    model_mem[r] = d;
    checks++; if (wr_log.size() !== base + 1) begin failures++; $display("FAIL rm_after got=%0d exp=%0d", wr_log.size() - base, 1); end
    else begin
      checks++; if (wr_log[base] !== {r, d}) begin failures++; $display("FAIL rm_after_entry got=%h exp=%h", wr_log[base], {r, d}); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 8'($urandom);
      model_mem[i] = env_mem[i];
    end
    test_reset();
    test_single_write();
    test_wrong_addr();
    test_read();
    test_burst_write();
    test_wrap_read();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
